// File: rtl/threeway_round_ctrl_if.sv
// Bundle of the block-in / round-loop / result-out signals of the 3-Way
// round controller. The controller sits on the slave side. The environment
// (plaintext source, external round logic, ciphertext consumer) sits on the
// master side.
interface threeway_round_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_block;
  logic [95:0] in_key;
  logic [95:0] mix_x;
  logic [95:0] rnd_y;
  logic [3:0]  round_idx;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  in_valid, in_block, in_key, rnd_y, out_ready,
    output in_ready, mix_x, round_idx, out_valid
  );

  modport master (
    output in_valid, in_block, in_key, rnd_y, out_ready,
    input  in_ready, mix_x, round_idx, out_valid
  );
endinterface

// File: rtl/threeway_round_ctrl.sv
// Iterative round controller for 3-Way encryption.
// The block holds the cipher state, the key and the round constant. Each cycle
// it presents state ^ key ^ rc-injection on mix_x to the external theta input.
// It then takes back the completed round result on rnd_y in the same cycle.
// After NROUNDS rounds, mix_x holds the final mix word. That word stays on
// mix_x until the consumer accepts it.
module threeway_round_ctrl #(
  parameter int unsigned NROUNDS  = 11,
  parameter logic [15:0] START_RC = 16'h0b0b
) (
  input logic                  clk,
  input logic                  rst_n,
  threeway_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

  fsm_t        r_fsm;
  fsm_t        w_fsm_nxt;
  logic [95:0] r_state;
  logic [95:0] w_state_nxt;
  logic [95:0] r_key;
  logic [95:0] w_key_nxt;
  logic [15:0] r_rc;
  logic [15:0] w_rc_nxt;
  logic [3:0]  r_round;
  logic [3:0]  w_round_nxt;
  logic [95:0] w_rc_inj;

  // Round-constant step: shift left and reduce by the 3-Way polynomial 0x11011.
  function automatic logic [15:0] rc_step(input logic [15:0] rc);
    logic [16:0] t;
    t = {rc, 1'b0};
    if (t[16]) begin
      t = t ^ 17'h11011;
    end else begin
      t = t;
    end
    return t[15:0];
  endfunction

  // The round constant enters the a2 low half [79:64] and the a0 high half [31:16].
  assign w_rc_inj = {16'h0000, r_rc, 32'h0000_0000, r_rc, 16'h0000};

  assign bus.mix_x     = r_state ^ r_key ^ w_rc_inj;
  assign bus.round_idx = r_round;
  assign bus.in_ready  = (r_fsm == S_IDLE);
  assign bus.out_valid = (r_fsm == S_DONE);

  // State register for the FSM and datapath. Reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= S_IDLE;
      r_state <= 96'd0;
      r_key   <= 96'd0;
      r_rc    <= START_RC;
      r_round <= 4'd0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_rc    <= w_rc_nxt;
      r_round <= w_round_nxt;
    end
  end

  // Next-state logic: load on accept, iterate rounds in RUN, hold until handshake in DONE.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_rc_nxt    = r_rc;
    w_round_nxt = r_round;
    case (r_fsm)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_state_nxt = bus.in_block;
          w_key_nxt   = bus.in_key;
          w_rc_nxt    = START_RC;
          w_round_nxt = 4'd0;
          w_fsm_nxt   = S_RUN;
        end else begin
          w_fsm_nxt   = S_IDLE;
        end
      end
      S_RUN: begin
        w_state_nxt = bus.rnd_y;
        w_rc_nxt    = rc_step(r_rc);
        w_round_nxt = r_round + 4'd1;
        if (r_round == LAST_ROUND) begin
          w_fsm_nxt = S_DONE;
        end else begin
          w_fsm_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_round_nxt = 4'd0;
          w_fsm_nxt   = S_IDLE;
        end else begin
          w_fsm_nxt   = S_DONE;
        end
      end
      default: begin
        w_fsm_nxt   = S_IDLE;
        w_round_nxt = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_threeway_round_ctrl.sv
// Directed self-checking bench for threeway_round_ctrl.
module tb_threeway_round_ctrl;

  logic clk;
  logic rst_n;
  logic use_f;
  int   n_cmp;
  int   n_err;
  int   acc_cnt;
  int   acc_pos [0:3];
  logic [95:0] exp_fin;

  logic [15:0] rc_tbl [0:11] = '{16'h0b0b, 16'h1616, 16'h2c2c, 16'h5858,
                                 16'hb0b0, 16'h7171, 16'he2e2, 16'hd5d5,
                                 16'hbbbb, 16'h6767, 16'hcece, 16'h8d8d};

  threeway_round_ctrl_if bus ();

  threeway_round_ctrl #(.NROUNDS(11), .START_RC(16'h0b0b)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in round function returned combinationally from mix_x.
  function automatic logic [95:0] f_rnd(input logic [95:0] x);
    return {x[94:0], x[95]} ^ 96'h5a5a5a5a_0f0f0f0f_c3c3c3c3;
  endfunction

  function automatic logic [95:0] inj(input logic [15:0] rc);
    logic [95:0] v;
    v = 96'd0;
    v[79:64] = rc;
    v[31:16] = rc;
    return v;
  endfunction

  function automatic logic [15:0] rc_nxt(input logic [15:0] rc);
    return rc[15] ? ({rc[14:0], 1'b0} ^ 16'h1011) : {rc[14:0], 1'b0};
  endfunction

  // Reference final mix word for a block run with f_rnd as the round function.
  function automatic logic [95:0] model_final(input logic [95:0] blk, input logic [95:0] key);
    logic [95:0] s;
    logic [15:0] rc;
    s  = blk;
    rc = 16'h0b0b;
    for (int r = 0; r < 11; r++) begin
      s  = f_rnd(s ^ key ^ inj(rc));
      rc = rc_nxt(rc);
    end
    return s ^ key ^ inj(rc);
  endfunction

  assign bus.rnd_y = use_f ? f_rnd(bus.mix_x) : 96'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    use_f = 1'b0;
    rst_n = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_block  = 96'd0;
    bus.in_key    = 96'd0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    // Reset values
    chk("rst_in_ready",  96'(bus.in_ready),  96'd1);
    chk("rst_out_valid", 96'(bus.out_valid), 96'd0);
    chk("rst_round_idx", 96'(bus.round_idx), 96'd0);
    chk("rst_mix_x",     bus.mix_x,          96'h00000b0b_00000000_0b0b0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Zero vector / constant walk, with backpressure in DONE
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("zero_first_mix", bus.mix_x, 96'h00000b0b_00000000_0b0b0000);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("walk_mix_%0d", k),   bus.mix_x,          inj(rc_tbl[k]));
      chk($sformatf("walk_round_%0d", k), 96'(bus.round_idx), 96'(k));
      chk($sformatf("walk_ov_%0d", k),    96'(bus.out_valid), 96'd0);
      chk($sformatf("walk_ir_%0d", k),    96'(bus.in_ready),  96'd0);
      tick();
    end
    chk("done_mix",   bus.mix_x,          96'h00008d8d_00000000_8d8d0000);
    chk("done_ov",    96'(bus.out_valid), 96'd1);
    chk("done_round", 96'(bus.round_idx), 96'd11);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      tick();
      chk($sformatf("bp_ov_%0d", k),  96'(bus.out_valid), 96'd1);
      chk($sformatf("bp_mix_%0d", k), bus.mix_x,          96'h00008d8d_00000000_8d8d0000);
      chk($sformatf("bp_ir_%0d", k),  96'(bus.in_ready),  96'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("rel_ir", 96'(bus.in_ready),  96'd1);
    chk("rel_ov", 96'(bus.out_valid), 96'd0);

    // Feedback through a stand-in round function
    use_f = 1'b1;
    bus.in_block = 96'h00000001_00000001_00000001;
    bus.in_key   = 96'h3c3c3c3c_12345678_deadbeef;
    exp_fin = model_final(bus.in_block, bus.in_key);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_block = 96'hffffffff_ffffffff_ffffffff;
    bus.in_key   = 96'd0;
    for (int k = 0; k < 10; k++) tick();
    chk("fn_ov_early", 96'(bus.out_valid), 96'd0);
    tick();
    chk("fn_ov",  96'(bus.out_valid), 96'd1);
    chk("fn_mix", bus.mix_x,          exp_fin);
    tick();
    chk("fn_back_idle", 96'(bus.in_ready), 96'd1);

    // in_valid held high: one accept every 13 cycles
    use_f   = 1'b0;
    acc_cnt = 0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 39; i++) begin
      if (bus.in_ready) begin
        if (acc_cnt < 4) acc_pos[acc_cnt] = i;
        acc_cnt++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("cont_acc_cnt", 96'(acc_cnt),    96'd3);
    chk("cont_acc_1",   96'(acc_pos[1]), 96'd13);
    chk("cont_acc_2",   96'(acc_pos[2]), 96'd26);
    chk("cont_idle",    96'(bus.in_ready), 96'd1);

    // Reset mid-RUN, then a fresh block completes
    use_f = 1'b1;
    bus.in_block = 96'h01234567_89abcdef_fedcba98;
    bus.in_key   = 96'h0f1e2d3c_4b5a6978_8796a5b4;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("mid_round6", 96'(bus.round_idx), 96'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov",    96'(bus.out_valid), 96'd0);
    chk("mid_rst_ir",    96'(bus.in_ready),  96'd1);
    chk("mid_rst_round", 96'(bus.round_idx), 96'd0);
    chk("mid_rst_mix",   bus.mix_x,          96'h00000b0b_00000000_0b0b0000);
    tick();
    rst_n = 1'b1;
    tick();
    bus.in_block = 96'h00000000_00000000_00000001;
    bus.in_key   = 96'd0;
    exp_fin = model_final(bus.in_block, bus.in_key);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 11; k++) tick();
    chk("post_rst_ov",  96'(bus.out_valid), 96'd1);
    chk("post_rst_mix", bus.mix_x,          exp_fin);
    tick();
    chk("post_rst_idle", 96'(bus.in_ready), 96'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
